// File: rtl/gpu_video_pkg.sv
// Shared video timing defaults, sync polarity constants and helpers used by
// the framebuffer scanout and the GPU control block's resolution registers.
package gpu_video_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // One stage of the alignment delay line between read issue and output.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic en;
    } align_t;

    function automatic int unsigned calc_h_total(int unsigned act, int unsigned fp,
                                                 int unsigned sync, int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned calc_v_total(int unsigned act, int unsigned fp,
                                                 int unsigned sync, int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters with active/sync decode, frame boundary strobe, frame_start
// pulse and vblank, all referenced to the stage-0 counter position.
module video_timing_gen
    import gpu_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic active_o,
    output logic hsync_raw_o,
    output logic vsync_raw_o,
    output logic boundary_o,
    output logic frame_start_o,
    output logic vblank_o
);

    localparam int unsigned H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, v_last;
    logic          frame_start_q, vblank_q;

    always_comb begin
        h_last  = (h_cnt_q == HW'(H_TOTAL - 1));
        v_last  = (v_cnt_q == VW'(V_TOTAL - 1));
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= h_last && v_last;
            // Decoded from the next count so vblank lines up with v_cnt itself.
            vblank_q      <= (v_cnt_d >= VW'(V_ACTIVE));
        end
    end

    assign active_o      = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    assign hsync_raw_o   = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                           (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_raw_o   = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                           (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
    assign boundary_o    = h_last && v_last;
    assign frame_start_o = frame_start_q;
    assign vblank_o      = vblank_q;

endmodule

// File: rtl/fbuf_scanout.sv
// Framebuffer read side: linear BRAM reads per active pixel from a base latched
// at frame boundaries, realigned with sync/de to feed the video encoder.
module fbuf_scanout
    import gpu_video_pkg::*;
#(
    parameter int unsigned FBUF_ADDR_WIDTH = 19,
    parameter int unsigned FBUF_DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned H_FP            = DEF_H_FP,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BP            = DEF_H_BP,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned V_FP            = DEF_V_FP,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BP            = DEF_V_BP,
    parameter logic        SYNC_POL        = SYNC_ACTIVE_LOW
) (
    input  logic                       vid_aclk,
    input  logic                       vid_aresetn,
    input  logic                       scan_enable,
    input  logic [FBUF_ADDR_WIDTH-1:0] scan_base_addr,
    output logic                       fbuf_en_rd,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rdata,
    output logic [FBUF_DATA_WIDTH-1:0] vid_data,
    output logic                       vid_de,
    output logic                       vid_hsync,
    output logic                       vid_vsync,
    output logic                       frame_start,
    output logic                       vblank
);

    localparam int RDL = int'(RD_LATENCY);

    logic active, hsync_raw, vsync_raw, boundary;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i         (vid_aclk),
        .rst_n_i       (vid_aresetn),
        .active_o      (active),
        .hsync_raw_o   (hsync_raw),
        .vsync_raw_o   (vsync_raw),
        .boundary_o    (boundary),
        .frame_start_o (frame_start),
        .vblank_o      (vblank)
    );

    // addr_q itself carries the latched base: it is loaded from scan_base_addr
    // at the boundary and only walks forward through active pixels afterwards.
    logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       en_q, en_d;

    always_comb begin
        addr_d = addr_q;
        en_d   = en_q;
        if (boundary) begin
            addr_d = scan_base_addr;
            en_d   = scan_enable;
        end else if (active) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
        if (!vid_aresetn) begin
            addr_q <= '0;
            en_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            en_q   <= en_d;
        end
    end

    assign fbuf_en_rd = active && en_q;
    assign fbuf_addr  = addr_q;

    align_t stage0;
    align_t dl_q [RDL];
    align_t dly;

    assign stage0 = '{de: active, hs: hsync_raw, vs: vsync_raw, en: en_q};
    assign dly    = dl_q[RDL-1];

    always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
        if (!vid_aresetn) begin
            for (int i = 0; i < RDL; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= stage0;
            for (int i = 1; i < RDL; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    logic [FBUF_DATA_WIDTH-1:0] vid_data_q;
    logic                       vid_de_q, vid_hsync_q, vid_vsync_q;

    always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
        if (!vid_aresetn) begin
            vid_data_q  <= '0;
            vid_de_q    <= 1'b0;
            vid_hsync_q <= ~SYNC_POL;
            vid_vsync_q <= ~SYNC_POL;
        end else begin
            // Data is forced to zero while disabled so stale BRAM output never leaks.
            vid_data_q  <= (dly.de && dly.en) ? fbuf_rdata : '0;
            vid_de_q    <= dly.de;
            vid_hsync_q <= dly.hs ? SYNC_POL : ~SYNC_POL;
            vid_vsync_q <= dly.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_de    = vid_de_q;
    assign vid_hsync = vid_hsync_q;
    assign vid_vsync = vid_vsync_q;

endmodule

// File: tb/tb_fbuf_scanout.sv
// Directed bench for fbuf_scanout on a 14x7 raster, checked every cycle against
// a position-based model plus literal spot checks.
module tb_fbuf_scanout;

    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          scan_enable = 1'b0;
    logic [AW-1:0] scan_base_addr = '0;
    logic          fbuf_en_rd;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_rdata = '0;
    logic [DW-1:0] vid_data;
    logic          vid_de, vid_hsync, vid_vsync, frame_start, vblank;

    fbuf_scanout #(
        .FBUF_ADDR_WIDTH (AW),
        .FBUF_DATA_WIDTH (DW),
        .RD_LATENCY      (1),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (1'b0)
    ) dut (
        .vid_aclk       (clk),
        .vid_aresetn    (rst_n),
        .scan_enable    (scan_enable),
        .scan_base_addr (scan_base_addr),
        .fbuf_en_rd     (fbuf_en_rd),
        .fbuf_addr      (fbuf_addr),
        .fbuf_rdata     (fbuf_rdata),
        .vid_data       (vid_data),
        .vid_de         (vid_de),
        .vid_hsync      (vid_hsync),
        .vid_vsync      (vid_vsync),
        .frame_start    (frame_start),
        .vblank         (vblank)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, data = low byte of the address.
    always @(posedge clk) begin
        if (fbuf_en_rd) fbuf_rdata <= fbuf_addr[7:0];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;
    bit            fr_en   [0:15];
    logic [AW-1:0] fr_base [0:15];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
        end
    endtask

    function automatic bit in_active(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    // Address at raster cycle m = frame base + active pixels already passed.
    function automatic logic [AW-1:0] addr_at(int m);
        int h, v, f, cnt;
        h = m % HT;
        v = (m / HT) % VT;
        f = m / FT;
        cnt = (v < VA) ? v * HA + ((h < HA) ? h : HA) : VA * HA;
        return AW'(32'(fr_base[f]) + 32'(cnt));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            fr_en[i]   = 1'b0;
            fr_base[i] = '0;
        end
        n = 0;
    endtask

    // Compare all outputs for cycle n at the falling edge, then advance.
    task automatic step();
        int h, v, f, p, hp, vp, fp;
        logic [AW-1:0] a;
        logic [DW-1:0] exp_data;
        logic exp_de, exp_hs, exp_vs;
        @(negedge clk);
        if (n > 0 && n % FT == 0) begin
            fr_en[n / FT]   = scan_enable;
            fr_base[n / FT] = scan_base_addr;
        end
        h = n % HT; v = (n / HT) % VT; f = n / FT;
        check("fbuf_en_rd", 32'(fbuf_en_rd), 32'(in_active(h, v) && fr_en[f]));
        check("fbuf_addr", 32'(fbuf_addr), 32'(addr_at(n)));
        check("frame_start", 32'(frame_start), 32'(n > 0 && n % FT == 0));
        check("vblank", 32'(vblank), 32'(v >= VA));
        if (n >= 2) begin
            p = n - 2;
            hp = p % HT; vp = (p / HT) % VT; fp = p / FT;
            a = addr_at(p);
            exp_de   = in_active(hp, vp);
            exp_data = (exp_de && fr_en[fp]) ? a[7:0] : 8'h00;
            exp_hs   = !(hp >= HA + HFP && hp < HA + HFP + HS);
            exp_vs   = !(vp >= VA + VFP && vp < VA + VFP + VS);
        end else begin
            exp_de = 1'b0; exp_data = 8'h00; exp_hs = 1'b1; exp_vs = 1'b1;
        end
        check("vid_de", 32'(vid_de), 32'(exp_de));
        check("vid_data", 32'(vid_data), 32'(exp_data));
        check("vid_hsync", 32'(vid_hsync), 32'(exp_hs));
        check("vid_vsync", 32'(vid_vsync), 32'(exp_vs));
        n++;
    endtask

    task automatic run_to(int target);
        while (n <= target) step();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_en_rd"}, 32'(fbuf_en_rd), 32'h0);
        check({tag, "_addr"},  32'(fbuf_addr), 32'h0);
        check({tag, "_data"},  32'(vid_data), 32'h0);
        check({tag, "_de"},    32'(vid_de), 32'h0);
        check({tag, "_hsync"}, 32'(vid_hsync), 32'h1);
        check({tag, "_vsync"}, 32'(vid_vsync), 32'h1);
        check({tag, "_fstart"}, 32'(frame_start), 32'h0);
        check({tag, "_vblank"}, 32'(vblank), 32'h0);
    endtask

    initial begin
        scan_enable    = 1'b1;
        scan_base_addr = 19'h00100;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst0");
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_model();

        run_to(97);  check("lit_fs_97", 32'(frame_start), 32'h0);
        run_to(98);  check("lit_fs_98", 32'(frame_start), 32'h1);
                     check("lit_addr_98", 32'(fbuf_addr), 32'h100);
                     check("lit_rd_98", 32'(fbuf_en_rd), 32'h1);
        run_to(100); check("lit_de_100", 32'(vid_de), 32'h1);
                     check("lit_data_100", 32'(vid_data), 32'h00);
        run_to(109); check("lit_hs_109", 32'(vid_hsync), 32'h1);
        run_to(110); check("lit_hs_110", 32'(vid_hsync), 32'h0);
        run_to(111); check("lit_hs_111", 32'(vid_hsync), 32'h0);
        run_to(112); check("lit_hs_112", 32'(vid_hsync), 32'h1);
        run_to(117); check("lit_data_117", 32'(vid_data), 32'h0B);
        run_to(128); scan_base_addr = 19'h00200;
        run_to(147); check("lit_addr_147", 32'(fbuf_addr), 32'h11F);
        run_to(149); check("lit_data_149", 32'(vid_data), 32'h1F);
        run_to(196); check("lit_addr_196", 32'(fbuf_addr), 32'h200);
                     check("lit_fs_196", 32'(frame_start), 32'h1);
        run_to(220); scan_base_addr = 19'h7FFFE;
        run_to(294); check("lit_addr_294", 32'(fbuf_addr), 32'h7FFFE);
        run_to(295); check("lit_addr_295", 32'(fbuf_addr), 32'h7FFFF);
        run_to(296); check("lit_addr_296", 32'(fbuf_addr), 32'h00000);
                     check("lit_data_296", 32'(vid_data), 32'hFE);
        run_to(297); check("lit_addr_297", 32'(fbuf_addr), 32'h00001);
        run_to(299); check("lit_data_299", 32'(vid_data), 32'h01);
        run_to(320); scan_enable = 1'b0;
        run_to(392); check("lit_rd_392", 32'(fbuf_en_rd), 32'h0);
        run_to(394); check("lit_de_394", 32'(vid_de), 32'h1);
                     check("lit_data_394", 32'(vid_data), 32'h0);
        run_to(420); scan_enable = 1'b1; scan_base_addr = 19'h00100;
        run_to(463); check("lit_vs_463", 32'(vid_vsync), 32'h1);
        run_to(464); check("lit_vs_464", 32'(vid_vsync), 32'h0);
        run_to(477); check("lit_vs_477", 32'(vid_vsync), 32'h0);
        run_to(478); check("lit_vs_478", 32'(vid_vsync), 32'h1);
        run_to(510); check("lit_de_510", 32'(vid_de), 32'h1);
                     check("lit_data_510", 32'(vid_data), 32'h0C);

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst1");
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_model();

        run_to(97);  check("lit2_fs_97", 32'(frame_start), 32'h0);
        run_to(98);  check("lit2_fs_98", 32'(frame_start), 32'h1);
        run_to(100); check("lit2_de_100", 32'(vid_de), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
